ibex_rf_wr_sched: RTL



---
 rtl/ibex_rf_wr_sched_if.sv | 37 +++
 rtl/ibex_rf_wr_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wr_sched_if.sv
// Writeback-side bundle for ibex_rf_wr_sched: two write requesters, the wipe
// request, and the registered RF write port the scheduler drives.
interface ibex_rf_wr_sched_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 lsu_req_i;
    logic [4:0]           lsu_addr_i;
    logic [DataWidth-1:0] lsu_wdata_i;
    logic                 lsu_gnt_o;
    logic                 ex_req_i;
    logic [4:0]           ex_addr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 ex_gnt_o;
    logic                 clear_req_i;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic                 init_done_o;

    // Requester/environment side.
    modport master (
        output lsu_req_i, lsu_addr_i, lsu_wdata_i,
        output ex_req_i, ex_addr_i, ex_wdata_i,
        output clear_req_i,
        input  lsu_gnt_o, ex_gnt_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, init_done_o
    );

    // Scheduler side.
    modport slave (
        input  lsu_req_i, lsu_addr_i, lsu_wdata_i,
        input  ex_req_i, ex_addr_i, ex_wdata_i,
        input  clear_req_i,
        output lsu_gnt_o, ex_gnt_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, init_done_o
    );
endinterface

// File: rtl/ibex_rf_wr_sched.sv
// Shares the single RF write port between LSU (priority) and EX writeback.
// Define RF_WR_SCHED_INIT_EN to compile in the zero-initialisation sweep.
module ibex_rf_wr_sched #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input logic                clk_int,
    input logic                rst_ni,
    ibex_rf_wr_sched_if.slave  bus
);
    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

    logic                 grant_en;
    logic                 lsu_gnt;
    logic                 ex_gnt;
    logic [4:0]           raw_addr;
    logic [4:0]           win_addr;
    logic [DataWidth-1:0] win_wdata;

    logic                 we_reg, we_next;
    logic [4:0]           waddr_reg, waddr_next;
    logic [DataWidth-1:0] wdata_reg, wdata_next;

`ifdef RF_WR_SCHED_INIT_EN
    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    state_e     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       done_reg, done_next;

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= INIT;
            cnt_reg   <= 5'd1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                if (cnt_reg == LastAddr) begin
                    state_next = IDLE;
                    cnt_next   = 5'd1;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            IDLE: begin
                // A wipe request while already sweeping is not a restart.
                if (bus.clear_req_i) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign grant_en = rst_ni & (state_reg == IDLE);
`else
    logic unused_clear;

    assign unused_clear = bus.clear_req_i;
    assign grant_en     = rst_ni;
`endif

    // Output process: grants are combinational, RF port values are next-state.
    always_comb begin
        lsu_gnt   = grant_en & bus.lsu_req_i;
        ex_gnt    = grant_en & bus.ex_req_i & ~bus.lsu_req_i;
        raw_addr  = bus.lsu_req_i ? bus.lsu_addr_i : bus.ex_addr_i;
        win_addr  = RV32E ? {1'b0, raw_addr[3:0]} : raw_addr;
        win_wdata = bus.lsu_req_i ? bus.lsu_wdata_i : bus.ex_wdata_i;

        we_next    = 1'b0;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;
`ifdef RF_WR_SCHED_INIT_EN
        done_next  = done_reg;
        if (state_reg == INIT) begin
            we_next    = 1'b1;
            waddr_next = cnt_reg;
            wdata_next = '0;
            if (cnt_reg == LastAddr) begin
                done_next = 1'b1;
            end
        end else begin
            if (bus.clear_req_i) begin
                done_next = 1'b0;
            end
`endif
            // x0 is hardwired: the request is consumed without a write.
            if ((lsu_gnt | ex_gnt) && (win_addr != 5'd0)) begin
                we_next    = 1'b1;
                waddr_next = win_addr;
                wdata_next = win_wdata;
            end
`ifdef RF_WR_SCHED_INIT_EN
        end
`endif
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            we_reg    <= 1'b0;
            waddr_reg <= 5'd0;
            wdata_reg <= '0;
        end else begin
            we_reg    <= we_next;
            waddr_reg <= waddr_next;
            wdata_reg <= wdata_next;
        end
    end

`ifdef RF_WR_SCHED_INIT_EN
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_next;
        end
    end

    assign bus.init_done_o = done_reg;
`else
    assign bus.init_done_o = 1'b1;
`endif

    assign bus.lsu_gnt_o  = lsu_gnt;
    assign bus.ex_gnt_o   = ex_gnt;
    assign bus.rf_we_o    = we_reg;
    assign bus.rf_waddr_o = waddr_reg;
    assign bus.rf_wdata_o = wdata_reg;
endmodule
